tdc_hit_scheduler: RTL and testbench

TDC_HIT_SCHEDULER -- requirements
Module: tdc_hit_scheduler

---
 rtl/tdc_hit_scheduler.sv | 148 ++++++++++++++
 tb/tb_tdc_hit_scheduler.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tdc_hit_scheduler.sv
// Multi-channel TDC hit scheduler: per-channel hit capture, round-robin arbitration,
// popcount fine-time encoding with thermometer check, and a valid/ready record output.
module tdc_hit_scheduler #(
    parameter int NCH  = 8,
    parameter int FT_W = 32,
    parameter int CT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enable,
    input  logic [NCH-1:0]           hit_valid,
    input  logic [NCH*FT_W-1:0]      hit_fine,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(NCH)-1:0]   out_chan,
    output logic [CT_W-1:0]          out_coarse,
    output logic [$clog2(FT_W):0]    out_fine,
    output logic                     out_err,
    output logic [15:0]              drop_cnt,
    output logic                     busy
);
    localparam int CH_W = $clog2(NCH);
    localparam int FN_W = $clog2(FT_W) + 1;

    typedef enum logic [1:0] {IDLE, ENC, OUT} state_t;

    state_t            state_reg, state_next;
    logic [CT_W-1:0]   coarse_reg;
    logic [NCH-1:0]    pending_reg, pending_next;
    logic [NCH-1:0]    grant_vec, accept_vec, drop_vec;
    logic [CH_W-1:0]   last_grant_reg, grant_idx, scan_idx;
    logic              grant_found, grant_fire;
    logic [15:0]       drop_cnt_reg, drop_cnt_next;
    logic [16:0]       drop_sum;

    logic [FT_W-1:0]   hold_fine [NCH];
    logic [CT_W-1:0]   hold_coarse [NCH];

    logic [FT_W-1:0]   pipe_fine_reg;
    logic [CT_W-1:0]   pipe_coarse_reg;
    logic [CH_W-1:0]   pipe_chan_reg;
    logic [FN_W-1:0]   pop;
    logic [FT_W-1:0]   therm;

    // Round-robin search starts just above the last grant; offset NCH wraps back to it.
    always_comb begin
        grant_idx   = '0;
        grant_found = 1'b0;
        scan_idx    = '0;
        for (int k = 1; k <= NCH; k++) begin
            scan_idx = last_grant_reg + CH_W'(k);
            if (!grant_found && pending_reg[scan_idx]) begin
                grant_idx   = scan_idx;
                grant_found = 1'b1;
            end
        end
    end

    assign grant_fire = (state_reg == IDLE) && grant_found;

    // A hit on the channel being granted this edge refills the slot instead of dropping.
    for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
        assign grant_vec[gi]    = grant_fire && (grant_idx == CH_W'(gi));
        assign accept_vec[gi]   = enable && hit_valid[gi] && (!pending_reg[gi] || grant_vec[gi]);
        assign drop_vec[gi]     = enable && hit_valid[gi] && pending_reg[gi] && !grant_vec[gi];
        assign pending_next[gi] = accept_vec[gi] || (pending_reg[gi] && !grant_vec[gi]);
    end

    always_comb begin
        drop_sum = {1'b0, drop_cnt_reg};
        for (int i = 0; i < NCH; i++) begin
            drop_sum = drop_sum + 17'(drop_vec[i]);
        end
        drop_cnt_next = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end

    always_comb begin
        pop = '0;
        for (int j = 0; j < FT_W; j++) begin
            pop = pop + FN_W'(pipe_fine_reg[j]);
        end
    end

    // Ideal thermometer code for the measured popcount; any other pattern is an error.
    for (genvar gi = 0; gi < FT_W; gi++) begin : g_therm
        assign therm[gi] = (pop > FN_W'(gi));
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (grant_found) state_next = ENC;
            ENC:     state_next = OUT;
            OUT:     if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NCH; i++) begin
            if (accept_vec[i]) begin
                hold_fine[i]   <= hit_fine[i*FT_W +: FT_W];
                hold_coarse[i] <= coarse_reg;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= IDLE;
            pending_reg     <= '0;
            coarse_reg      <= '0;
            drop_cnt_reg    <= '0;
            last_grant_reg  <= CH_W'(NCH - 1);
            pipe_fine_reg   <= '0;
            pipe_coarse_reg <= '0;
            pipe_chan_reg   <= '0;
            out_chan        <= '0;
            out_coarse      <= '0;
            out_fine        <= '0;
            out_err         <= 1'b0;
        end else begin
            state_reg    <= state_next;
            pending_reg  <= pending_next;
            drop_cnt_reg <= drop_cnt_next;
            if (enable) begin
                coarse_reg <= coarse_reg + 1'b1;
            end
            if (grant_fire) begin
                pipe_fine_reg   <= hold_fine[grant_idx];
                pipe_coarse_reg <= hold_coarse[grant_idx];
                pipe_chan_reg   <= grant_idx;
                last_grant_reg  <= grant_idx;
            end
            if (state_reg == ENC) begin
                out_chan   <= pipe_chan_reg;
                out_coarse <= pipe_coarse_reg;
                out_fine   <= pop;
                out_err    <= (pipe_fine_reg != therm);
            end
        end
    end

    assign out_valid = (state_reg == OUT);
    assign drop_cnt  = drop_cnt_reg;
    assign busy      = (state_reg != IDLE) || (|pending_reg);

endmodule

// File: tb/tb_tdc_hit_scheduler.sv
// Directed bench for tdc_hit_scheduler: latency, arbitration order, encoding,
// drop handling, coarse wrap and mid-record reset, all against hand-computed values.
module tb_tdc_hit_scheduler;
    localparam int NCH  = 8;
    localparam int FT_W = 32;
    localparam int CT_W = 16;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                enable = 1'b0;
    logic [NCH-1:0]      hit_valid = '0;
    logic [NCH*FT_W-1:0] hit_fine = '0;
    logic                out_ready = 1'b1;
    logic                out_valid;
    logic [2:0]          out_chan;
    logic [CT_W-1:0]     out_coarse;
    logic [5:0]          out_fine;
    logic                out_err;
    logic [15:0]         drop_cnt;
    logic                busy;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    tdc_hit_scheduler #(.NCH(NCH), .FT_W(FT_W), .CT_W(CT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .hit_valid  (hit_valid),
        .hit_fine   (hit_fine),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_chan   (out_chan),
        .out_coarse (out_coarse),
        .out_fine   (out_fine),
        .out_err    (out_err),
        .drop_cnt   (drop_cnt),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        enable    = 1'b0;
        hit_valid = '0;
        out_ready = 1'b1;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic hit(input int ch, input logic [31:0] pat);
        hit_fine[ch*FT_W +: FT_W] = pat;
        hit_valid[ch] = 1'b1;
    endtask

    task automatic fire();
        step();
        hit_valid = '0;
    endtask

    // Waits (bounded) for a record, captures it, and consumes it when out_ready is high.
    task automatic get_rec(input string tag, output logic [2:0] ch, output logic [15:0] co,
                           output logic [5:0] fi, output logic er, output int at);
        logic ok;
        ok = 1'b0; ch = '0; co = '0; fi = '0; er = 1'b0; at = 0;
        for (int t = 0; t < 40 && !ok; t++) begin
            if (out_valid) begin
                ok = 1'b1;
                ch = out_chan; co = out_coarse; fi = out_fine; er = out_err;
                at = cyc;
            end else begin
                step();
            end
        end
        chk({tag, "_present"}, ok, 1'b1);
        if (ok && out_ready) step();
    endtask

    task automatic expect_rec(input string tag, input int ch_e, input int co_e, input int fi_e,
                              input int er_e);
        logic [2:0] ch; logic [15:0] co; logic [5:0] fi; logic er; int at;
        get_rec(tag, ch, co, fi, er, at);
        chk({tag, "_chan"}, ch, ch_e);
        if (co_e >= 0) chk({tag, "_coarse"}, co, co_e);
        chk({tag, "_fine"}, fi, fi_e);
        chk({tag, "_err"}, er, er_e);
    endtask

    initial begin
        logic [2:0] ch; logic [15:0] co; logic [5:0] fi; logic er;
        int at, prev_at, nvalid;
        logic [31:0] pat;
        logic [31:0] pats [4];
        int          fines [4];
        int          errs [4];
        pats[0] = 32'h000000F7; fines[0] = 7;  errs[0] = 1;
        pats[1] = 32'h00000000; fines[1] = 0;  errs[1] = 0;
        pats[2] = 32'hFFFFFFFF; fines[2] = 32; errs[2] = 0;
        pats[3] = 32'h00010000; fines[3] = 1;  errs[3] = 1;

        // Reset state
        #2;
        chk("rst_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_drop", drop_cnt, 0);
        chk("rst_fine", out_fine, 0);
        do_reset();

        // Single hit at coarse 5, latency N+2
        enable = 1'b1;
        repeat (5) step();
        hit(0, 32'h000000FF);
        fire();
        chk("lat_n0_valid", out_valid, 0);
        step();
        chk("lat_n1_valid", out_valid, 0);
        chk("lat_n1_busy", busy, 1);
        step();
        chk("lat_n2_valid", out_valid, 1);
        chk("lat_chan", out_chan, 0);
        chk("lat_coarse", out_coarse, 5);
        chk("lat_fine", out_fine, 8);
        chk("lat_err", out_err, 0);
        step();
        $display("[TB] single hit: chan 0 coarse 5 fine 8");

        // All eight channels at once after reset: order 0..7, 3 cycles apart
        do_reset();
        enable = 1'b1;
        for (int i = 0; i < NCH; i++) begin
            pat = '0;
            for (int j = 0; j <= i; j++) pat[j] = 1'b1;
            hit(i, pat);
        end
        fire();
        prev_at = 0;
        for (int k = 0; k < NCH; k++) begin
            get_rec("rr", ch, co, fi, er, at);
            chk("rr_chan", ch, k);
            chk("rr_coarse", co, 0);
            chk("rr_fine", fi, k + 1);
            chk("rr_err", er, 0);
            if (k > 0) chk("rr_spacing", at - prev_at, 3);
            prev_at = at;
            $display("[TB] rr record %0d: chan %0d fine %0d at cycle %0d", k, ch, fi, at);
        end
        chk("rr_drop", drop_cnt, 0);

        // Fine encoding corner patterns on channel 5
        for (int p = 0; p < 4; p++) begin
            hit(5, pats[p]);
            fire();
            expect_rec("enc", 5, -1, fines[p], errs[p]);
            $display("[TB] pattern 0x%08h: expect fine %0d err %0d", pats[p], fines[p], errs[p]);
        end

        // Back-pressure: first in OUT, second pending, third dropped
        do_reset();
        enable = 1'b1;
        out_ready = 1'b0;
        hit(3, 32'h3);
        fire();
        step();
        step();
        chk("bp_valid", out_valid, 1);
        hit(3, 32'hF);
        fire();
        hit(3, 32'hFF);
        fire();
        chk("bp_drop", drop_cnt, 1);
        chk("bp_hold_valid", out_valid, 1);
        chk("bp_hold_chan", out_chan, 3);
        chk("bp_hold_fine", out_fine, 2);
        chk("bp_busy", busy, 1);
        repeat (3) step();
        chk("bp_stable_fine", out_fine, 2);
        chk("bp_stable_coarse", out_coarse, 0);
        out_ready = 1'b1;
        expect_rec("bp_first", 3, 0, 2, 0);
        expect_rec("bp_second", 3, 3, 4, 0);
        nvalid = 0;
        for (int t = 0; t < 10; t++) begin
            step();
            if (out_valid) nvalid++;
        end
        chk("bp_no_third", nvalid, 0);
        chk("bp_idle_busy", busy, 0);
        $display("[TB] back-pressure: drop_cnt %0d", drop_cnt);

        // Hit on the edge its pending entry is granted is kept, not dropped
        hit(2, 32'h1);
        fire();
        hit(2, 32'h7);
        fire();
        expect_rec("regrant_a", 2, -1, 1, 0);
        expect_rec("regrant_b", 2, -1, 3, 0);
        chk("regrant_drop", drop_cnt, 1);

        // Hits ignored while disabled
        enable = 1'b0;
        hit(6, 32'hFF);
        fire();
        chk("dis_busy", busy, 0);
        step();
        chk("dis_valid", out_valid, 0);

        // Coarse wrap
        do_reset();
        enable = 1'b1;
        repeat (65535) step();
        hit(1, 32'h1);
        fire();
        hit(2, 32'h3);
        fire();
        expect_rec("wrap_hi", 1, 16'hFFFF, 1, 0);
        expect_rec("wrap_lo", 2, 0, 2, 0);
        $display("[TB] coarse wrap records checked");

        // Reset while a record waits in OUT and another is pending
        out_ready = 1'b0;
        hit(4, 32'hF);
        hit(5, 32'hF);
        fire();
        step();
        step();
        chk("mid_valid_before", out_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_valid_async", out_valid, 0);
        chk("mid_busy_async", busy, 0);
        chk("mid_chan_async", out_chan, 0);
        step();
        rst_n = 1'b1;
        out_ready = 1'b1;
        nvalid = 0;
        for (int t = 0; t < 10; t++) begin
            step();
            if (out_valid) nvalid++;
        end
        chk("mid_no_record", nvalid, 0);
        chk("mid_busy_after", busy, 0);
        $display("[TB] mid-record reset checked");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
